// File: rtl/conditional_subtractor_pkg.sv
// conditional_subtractor_pkg: shared FSM encoding and block/address sizing helpers.
package conditional_subtractor_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, PAD, DRAIN, OUTPUTTING} state_e;
  localparam int DRAIN_CYCLES = 3;
  function automatic int num_blocks(input int bits, input int width);
    return bits / width;
  endfunction
  function automatic int addr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conditional_subtractor_ram.sv
// xilinx_true_dual_port_read_first_2_clock_ram: read-first dual-port RAM, 2-cycle read latency.
// With INIT_EN the contents come from INIT_VALUE and the array is read-only.
module xilinx_true_dual_port_read_first_2_clock_ram
  import conditional_subtractor_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 8,
  parameter int ADDR_WIDTH = addr_width(RAM_DEPTH),
  parameter bit INIT_EN = 1'b0,
  parameter string INIT_FILE = "",
  parameter logic [RAM_WIDTH*RAM_DEPTH-1:0] INIT_VALUE = '0
)(
  input  logic                  clka,
  input  logic                  clkb,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]  dina,
  input  logic [RAM_WIDTH-1:0]  dinb,
  input  logic                  wea,
  input  logic                  web,
  input  logic                  ena,
  input  logic                  enb,
  input  logic                  rsta,
  input  logic                  rstb,
  input  logic                  regcea,
  input  logic                  regceb,
  output logic [RAM_WIDTH-1:0]  douta,
  output logic [RAM_WIDTH-1:0]  doutb
);
  logic [RAM_WIDTH-1:0] rd_a, rd_b, ra_q, rb_q;
  function automatic logic [RAM_DEPTH-1:0][RAM_WIDTH-1:0] init_mem();
    for (int i = 0; i < RAM_DEPTH; i++) init_mem[i] = INIT_VALUE[i*RAM_WIDTH +: RAM_WIDTH];
  endfunction
  if (INIT_EN) begin : g_rom
    logic [RAM_DEPTH-1:0][RAM_WIDTH-1:0] rom = init_mem();
    logic unused_w;
    assign unused_w = ^{dina, dinb, wea, web};
    assign rd_a = rom[addra];
    assign rd_b = rom[addrb];
  end else begin : g_ram
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    // Both ports commit writes on clka so the array has a single writer; clkb must be clka-synchronous.
    always_ff @(posedge clka) begin
      if (ena && wea) mem[addra] <= dina;
      if (enb && web) mem[addrb] <= dinb;
    end
    assign rd_a = mem[addra];
    assign rd_b = mem[addrb];
  end
  always_ff @(posedge clka) begin
    if (ena) ra_q <= rd_a;
    if (rsta) douta <= '0;
    else if (regcea) douta <= ra_q;
  end
  always_ff @(posedge clkb) begin
    if (enb) rb_q <= rd_b;
    if (rstb) doutb <= '0;
    else if (regceb) doutb <= rb_q;
  end
endmodule

// File: rtl/conditional_subtractor.sv
// conditional_subtractor: streams T in, buffers T and T-N, streams out T-N if no final borrow else T.
// CSUB_STATUS_EN adds subtracted_out reporting which image is being streamed.
module conditional_subtractor
  import conditional_subtractor_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM = 4096,
  parameter string INIT_FILE = "n.mem",
  parameter logic [BITS_IN_NUM-1:0] INIT_VALUE = '0
)(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     final_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     final_out
`ifdef CSUB_STATUS_EN
  ,
  output logic                     subtracted_out
`endif
);
  localparam int W = REGISTER_SIZE;
  localparam int NB = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int AW = addr_width(NB);
  localparam logic [AW-1:0] LAST_K = AW'(NB - 1);
  localparam logic [AW:0] NB_A = (AW + 1)'(NB);
  localparam logic [AW:0] LAST_A = NB_A - 1'b1;
  localparam logic [AW:0] DRAIN_LAST = (AW + 1)'(DRAIN_CYCLES - 1);
  state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d, k1_q, k2_q, wr_k_q;
  logic [AW:0] cnt_q, cnt_d, rd_addr;
  logic [W-1:0] blk, t1_q, t2_q, n_blk, d, wr_t_q, wr_d_q, buf_unused_b, rom_unused_b;
  logic [1:0] v_q, ov_q, of_q;
  logic blk_v, last_k, rd_en, borrow_q, borrow_n, wr_v_q;
  always_ff @(posedge clk_in) state_q <= rst_in ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, CAPTURE: if (blk_v) state_d = last_k ? DRAIN : final_in ? PAD : CAPTURE;
      PAD:           if (last_k) state_d = DRAIN;
      DRAIN:         if (cnt_q == DRAIN_LAST) state_d = OUTPUTTING;
      OUTPUTTING:    if (of_q[1]) state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end
  always_comb begin
    ready_out = state_q == IDLE || state_q == CAPTURE;
    rd_en = state_q == OUTPUTTING && cnt_q < NB_A;
`ifdef CSUB_STATUS_EN
    subtracted_out = state_q == OUTPUTTING && !borrow_q;
`endif
  end
  assign valid_out = ov_q[1];
  assign final_out = of_q[1];
  assign blk_v = (valid_in && ready_out) || state_q == PAD;
  assign blk = state_q == PAD ? '0 : data_in;
  assign last_k = k_q == LAST_K;
  assign k_d = (state_d == CAPTURE || state_d == PAD) ? k_q + AW'(blk_v) : '0;
  assign cnt_d = state_q != state_d ? '0 : (state_q == DRAIN || rd_en) ? cnt_q + 1'b1 : cnt_q;
  assign rd_addr = (borrow_q ? '0 : NB_A) + cnt_q;
  // Block 0 always starts a fresh borrow chain.
  assign {borrow_n, d} = {1'b0, t2_q} - {1'b0, n_blk} - (W + 1)'(k2_q != '0 && borrow_q);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      k_q <= '0;
      cnt_q <= '0;
      v_q <= '0;
      borrow_q <= 1'b0;
      wr_v_q <= 1'b0;
      ov_q <= '0;
      of_q <= '0;
    end else begin
      k_q <= k_d;
      cnt_q <= cnt_d;
      v_q <= {v_q[0], blk_v};
      if (v_q[1]) borrow_q <= borrow_n;
      wr_v_q <= v_q[1];
      ov_q <= {ov_q[0], rd_en};
      of_q <= {of_q[0], rd_en && cnt_q == LAST_A};
    end
  end
  always_ff @(posedge clk_in) begin
    t1_q <= blk;
    t2_q <= t1_q;
    k1_q <= k_q;
    k2_q <= k1_q;
    wr_k_q <= k2_q;
    wr_t_q <= t2_q;
    wr_d_q <= d;
  end
  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(W), .RAM_DEPTH(NB), .ADDR_WIDTH(AW),
    .INIT_EN(1'b1), .INIT_FILE(INIT_FILE), .INIT_VALUE(INIT_VALUE)
  ) u_rom (
    .clka(clk_in), .clkb(clk_in), .addra(k_q), .addrb('0), .dina('0), .dinb('0),
    .wea(1'b0), .web(1'b0), .ena(1'b1), .enb(1'b0), .rsta(rst_in), .rstb(rst_in),
    .regcea(1'b1), .regceb(1'b0), .douta(n_blk), .doutb(rom_unused_b)
  );
  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH(W), .RAM_DEPTH(2 * NB), .ADDR_WIDTH(AW + 1)
  ) u_buf (
    .clka(clk_in), .clkb(clk_in), .addra(wr_v_q ? {1'b0, wr_k_q} : rd_addr),
    .addrb(NB_A + {1'b0, wr_k_q}), .dina(wr_t_q), .dinb(wr_d_q),
    .wea(wr_v_q), .web(wr_v_q), .ena(1'b1), .enb(1'b1), .rsta(rst_in), .rstb(rst_in),
    .regcea(ov_q[0]), .regceb(1'b0), .douta(data_out), .doutb(buf_unused_b)
  );
endmodule

// File: tb/tb_conditional_subtractor.sv
// tb_conditional_subtractor: randomized and directed checks against a 128-bit arithmetic model.
module tb_conditional_subtractor;
  localparam logic [127:0] N = 128'h10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] data_in = '0;
  logic valid_in = 1'b0;
  logic final_in = 1'b0;
  logic ready_out, valid_out, final_out, sub_o;
  logic [31:0] data_out;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conditional_subtractor #(
    .REGISTER_SIZE(32), .BITS_IN_NUM(128), .INIT_FILE(""), .INIT_VALUE(N)
  ) dut (
    .clk_in(clk), .rst_in(rst), .data_in(data_in), .valid_in(valid_in), .final_in(final_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .final_out(final_out)
`ifdef CSUB_STATUS_EN
    , .subtracted_out(sub_o)
`endif
  );
`ifndef CSUB_STATUS_EN
  assign sub_o = 1'b0;
`endif
  function automatic logic [127:0] ref_result(input logic [127:0] t);
    return t >= N ? t - N : t;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [127:0] t, input int n, input bit gaps, output int first, output int last);
    first = -1;
    last = -1;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        valid_in = 1'b0;
        final_in = 1'b0;
        step();
      end
      valid_in = 1'b1;
      data_in = t[i*32 +: 32];
      final_in = i == n - 1;
      for (int w = 0; w < 50 && !ready_out; w++) step();
      if (!ready_out) begin
        checks++;
        $display("FAIL send_ready: ready_out=%0b required 1", ready_out);
      end
      if (i == 0) first = cyc;
      last = cyc;
      step();
    end
    valid_in = 1'b0;
    final_in = 1'b0;
    data_in = $urandom;
  endtask
  task automatic collect(output logic [127:0] r, output int first, output logic [3:0] fin,
                         output logic [3:0] sub, output bit contig, output bit timeout,
                         output bit rdy_fin, output bit rdy_after);
    r = '0;
    fin = '0;
    sub = '0;
    contig = 1'b1;
    rdy_fin = 1'b1;
    first = -1;
    for (int w = 0; w < 40 && !valid_out; w++) step();
    timeout = !valid_out;
    if (!timeout) begin
      first = cyc;
      for (int i = 0; i < 4; i++) begin
        contig &= valid_out;
        r[i*32 +: 32] = data_out;
        fin[i] = final_out;
        sub[i] = sub_o;
        if (i == 3) rdy_fin = ready_out;
        step();
      end
      contig &= !valid_out;
    end
    rdy_after = ready_out;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (ready_out !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_out); else passed++;
    checks++; if (data_out !== 32'h0) $display("FAIL rst_data: got %h want 0", data_out); else passed++;
    checks++; if (valid_out !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_out); else passed++;
    checks++; if (final_out !== 1'b0) $display("FAIL rst_final: got %b want 0", final_out); else passed++;
`ifdef CSUB_STATUS_EN
    checks++; if (sub_o !== 1'b0) $display("FAIL rst_sub: got %b want 0", sub_o); else passed++;
`endif
    rst = 1'b0;
    step();
    checks++; if (ready_out !== 1'b1 || valid_out !== 1'b0) $display("FAIL post_rst: ready %b valid %b want 1 0", ready_out, valid_out); else passed++;
  endtask
  task automatic test_directed();
    logic [127:0] tv [5];
    logic [127:0] r, e;
    logic [3:0] fin, sub;
    bit contig, to, rf, ra;
    int fa, la, fv;
    tv = '{128'h15, 128'h0F, N, 128'h3, {32'h0, 32'h0, 32'h1, 32'h5}};
    for (int v = 0; v < 5; v++) begin
      e = ref_result(tv[v]);
      send(tv[v], 4, 1'b0, fa, la);
      collect(r, fv, fin, sub, contig, to, rf, ra);
      checks++; if (to) $display("FAIL dir%0d_timeout: no valid_out within 40 cycles", v); else passed++;
      checks++; if (r !== e) $display("FAIL dir%0d_data: got %h want %h", v, r, e); else passed++;
      checks++; if (fv - la !== 6) $display("FAIL dir%0d_latency: got %0d want 6", v, fv - la); else passed++;
      checks++; if (fin !== 4'b1000 || !contig) $display("FAIL dir%0d_framing: final %b contig %b want 1000 1", v, fin, contig); else passed++;
      checks++; if (rf !== 1'b0 || ra !== 1'b1) $display("FAIL dir%0d_ready: at_final %b after %b want 0 1", v, rf, ra); else passed++;
`ifdef CSUB_STATUS_EN
      checks++; if (sub !== {4{tv[v] >= N}}) $display("FAIL dir%0d_sub: got %b want %b", v, sub, {4{tv[v] >= N}}); else passed++;
`endif
    end
  endtask
  task automatic test_pad();
    logic [127:0] t, r;
    logic [3:0] fin, sub;
    bit contig, to, rf, ra;
    int fa, la, fv;
    t = 128'h20;
    send(t, 2, 1'b0, fa, la);
    checks++; if (ready_out !== 1'b0) $display("FAIL pad_ready1: got %b want 0", ready_out); else passed++;
    step();
    checks++; if (ready_out !== 1'b0) $display("FAIL pad_ready2: got %b want 0", ready_out); else passed++;
    collect(r, fv, fin, sub, contig, to, rf, ra);
    checks++; if (r !== 128'h10 || to) $display("FAIL pad_data: got %h want %h", r, 128'h10); else passed++;
    checks++; if (fv - la !== 8) $display("FAIL pad_latency: got %0d want 8", fv - la); else passed++;
    checks++; if (fin !== 4'b1000 || !contig) $display("FAIL pad_framing: final %b contig %b want 1000 1", fin, contig); else passed++;
  endtask
  task automatic test_reset_mid();
    logic [127:0] t, r;
    logic [3:0] fin, sub;
    bit contig, to, rf, ra, saw;
    int fa, la, fv;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      final_in = 1'b0;
      data_in = 32'h40 + 32'(i);
      rst = i == 2;
      step();
    end
    rst = 1'b0;
    valid_in = 1'b0;
    checks++; if (ready_out !== 1'b1) $display("FAIL midrst_ready: got %b want 1", ready_out); else passed++;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      saw |= valid_out;
      step();
    end
    checks++; if (saw) $display("FAIL midrst_no_output: valid_out seen 1 want 0"); else passed++;
    t = 128'h25;
    send(t, 4, 1'b0, fa, la);
    collect(r, fv, fin, sub, contig, to, rf, ra);
    checks++; if (r !== ref_result(t) || to) $display("FAIL midrst_after: got %h want %h", r, ref_result(t)); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [127:0] t, r;
    logic [3:0] fin, sub;
    bit contig, to, rf, ra;
    int fa, la, fv;
    t = 128'h1F;
    send(t, 4, 1'b0, fa, la);
    collect(r, fv, fin, sub, contig, to, rf, ra);
    t = 128'h11;
    send(t, 4, 1'b0, fa, la);
    checks++; if (fa !== fv + 4) $display("FAIL b2b_accept: first accept at %0d want %0d", fa, fv + 4); else passed++;
    collect(r, fv, fin, sub, contig, to, rf, ra);
    checks++; if (r !== 128'h1 || to) $display("FAIL b2b_data: got %h want %h", r, 128'h1); else passed++;
  endtask
  task automatic test_random();
    logic [127:0] t, r, e, mask;
    logic [3:0] fin, sub;
    bit contig, to, rf, ra;
    int fa, la, fv, n, mode;
    for (int it = 0; it < 20; it++) begin
      mode = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      t = mode == 0 ? 128'($urandom_range(0, 31)) :
          mode == 1 ? N - 1 + 128'($urandom_range(0, 2)) :
          {$urandom, $urandom, $urandom, $urandom};
      mask = n == 4 ? '1 : (128'd1 << (32 * n)) - 1;
      t &= mask;
      e = ref_result(t);
      send(t, n, 1'b1, fa, la);
      collect(r, fv, fin, sub, contig, to, rf, ra);
      checks++; if (r !== e || to) $display("FAIL rnd%0d_data: t %h got %h want %h", it, t, r, e); else passed++;
      checks++; if (fv - la !== 10 - n) $display("FAIL rnd%0d_latency: got %0d want %0d", it, fv - la, 10 - n); else passed++;
      checks++; if (fin !== 4'b1000 || !contig || ra !== 1'b1) $display("FAIL rnd%0d_framing: final %b contig %b ready %b want 1000 1 1", it, fin, contig, ra); else passed++;
`ifdef CSUB_STATUS_EN
      checks++; if (sub !== {4{t >= N}}) $display("FAIL rnd%0d_sub: got %b want %b", it, sub, {4{t >= N}}); else passed++;
`endif
    end
  endtask
  initial begin
    #1;
    test_reset();
    test_directed();
    test_pad();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end
endmodule
